// File: rtl/pc_trace_buffer_if.sv
// -----------------------------------------------------------------------------
// pc_trace_buffer_if
// Bundles the retirement stream, the trigger/rearm controls and the readout
// port of pc_trace_buffer into one interface.
//   master : the side that drives retirements, trigger config and rd_idx
//            and observes the trace results (core wrapper, bench).
//   slave  : the trace buffer itself.
// Signals:
//   valid/pc/instr   retirement stream (one entry per valid cycle)
//   trig_en/trig_pc  PC-match trigger configuration
//   rearm            one-cycle pulse that restarts a frozen capture
//   rd_idx/rd_data   readout, index 0 = oldest entry, data {cycle, pc, instr}
//   count/done/timeout/trig_cycle  capture status
// -----------------------------------------------------------------------------
interface pc_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = CYC_W + 2 * XLEN;

  logic            valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic            trig_en;
  logic [XLEN-1:0] trig_pc;
  logic            rearm;
  logic [AW-1:0]   rd_idx;
  logic [DW-1:0]   rd_data;
  logic [AW:0]     count;
  logic            done;
  logic            timeout;
  logic [CYC_W-1:0] trig_cycle;

  modport master (
    output valid, pc, instr, trig_en, trig_pc, rearm, rd_idx,
    input  rd_data, count, done, timeout, trig_cycle
  );

  modport slave (
    input  valid, pc, instr, trig_en, trig_pc, rearm, rd_idx,
    output rd_data, count, done, timeout, trig_cycle
  );
endinterface

// File: rtl/pc_trace_buffer.sv
// -----------------------------------------------------------------------------
// pc_trace_buffer
// Retirement-trace capture unit. Every retired instruction is stamped with a
// free-running cycle count and written into a circular buffer of DEPTH
// entries. A PC-match trigger (followed by POST_COUNT further entries) or a
// cycle-limit timeout freezes the buffer, which is then read oldest-first.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    pc_trace_buffer_if slave modport (retire stream, trigger config,
//          rearm, readout and status; all outputs registered)
// -----------------------------------------------------------------------------
module pc_trace_buffer #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 32,
  parameter int POST_COUNT = 4,
  parameter int MAX_CYCLES = 10000
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_trace_buffer_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = CYC_W + 2 * XLEN;

  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(MAX_CYCLES - 1);
  localparam logic [AW-1:0]    POST_INIT  = AW'(POST_COUNT);
  localparam logic [AW:0]      COUNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  state_e           state_q,      state_d;
  logic [CYC_W-1:0] cyc_q,        cyc_d;
  logic [AW-1:0]    wr_ptr_q,     wr_ptr_d;
  logic [AW:0]      count_q,      count_d;
  logic [AW-1:0]    post_left_q,  post_left_d;
  logic             timeout_q,    timeout_d;
  logic [CYC_W-1:0] trig_cycle_q, trig_cycle_d;
  logic             done_q,       done_d;
  logic [DW-1:0]    rd_data_q,    rd_data_d;

  logic [DW-1:0]    mem_q [DEPTH];

  logic             capturing_s;
  logic             wr_en_s;
  logic             hit_s;
  logic             last_cyc_s;
  logic [AW-1:0]    wr_ptr_inc_s;
  logic [AW:0]      count_inc_s;
  logic [AW-1:0]    rd_addr_s;
  logic             rd_in_range_s;
  logic [DW-1:0]    wr_data_s;

  // Per-cycle capture decisions derived from the current state.
  always_comb begin
    capturing_s  = (state_q != ST_FROZEN);
    wr_en_s      = capturing_s && bus.valid;
    // Only ARMED reacts to a PC match; repeats during POST are ignored.
    hit_s        = (state_q == ST_ARMED) && bus.valid && bus.trig_en &&
                   (bus.pc == bus.trig_pc);
    last_cyc_s   = capturing_s && (cyc_q == CYC_LAST);
    wr_ptr_inc_s = wr_ptr_q + AW'(1);
    if (count_q == COUNT_FULL) begin
      count_inc_s = count_q;
    end else begin
      count_inc_s = count_q + (AW + 1)'(1);
    end
    wr_data_s    = {cyc_q, bus.pc, bus.instr};
    // Window of valid entries ends just before wr_ptr; with count==DEPTH
    // the low bits of count are zero and the window starts at wr_ptr.
    rd_addr_s     = wr_ptr_q - count_q[AW-1:0] + bus.rd_idx;
    rd_in_range_s = ({1'b0, bus.rd_idx} < count_q);
  end

  // Next-state and next-value logic for the capture controller and readout.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    post_left_d  = post_left_q;
    timeout_d    = timeout_q;
    trig_cycle_d = trig_cycle_q;

    case (state_q)
      ST_ARMED: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (wr_en_s) begin
          wr_ptr_d = wr_ptr_inc_s;
          count_d  = count_inc_s;
        end else begin
          wr_ptr_d = wr_ptr_q;
          count_d  = count_q;
        end
        if (hit_s) begin
          trig_cycle_d = cyc_q;
          post_left_d  = POST_INIT;
          if (POST_COUNT == 0) begin
            state_d = ST_FROZEN;
          end else begin
            state_d = ST_POST;
          end
        end else begin
          state_d = ST_ARMED;
        end
        // Timeout wins over POST; a same-cycle trigger stamps the same cyc.
        if (last_cyc_s) begin
          state_d      = ST_FROZEN;
          timeout_d    = 1'b1;
          trig_cycle_d = cyc_q;
        end else begin
          timeout_d = timeout_q;
        end
      end

      ST_POST: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (wr_en_s) begin
          wr_ptr_d    = wr_ptr_inc_s;
          count_d     = count_inc_s;
          post_left_d = post_left_q - AW'(1);
          // The write that consumes the last post slot freezes on this edge.
          if (post_left_q == AW'(1)) begin
            state_d = ST_FROZEN;
          end else begin
            state_d = ST_POST;
          end
        end else begin
          wr_ptr_d    = wr_ptr_q;
          count_d     = count_q;
          post_left_d = post_left_q;
          state_d     = ST_POST;
        end
        // trig_cycle already holds the trigger stamp and is kept.
        if (last_cyc_s) begin
          state_d   = ST_FROZEN;
          timeout_d = 1'b1;
        end else begin
          timeout_d = timeout_q;
        end
      end

      ST_FROZEN: begin
        if (bus.rearm) begin
          state_d      = ST_ARMED;
          cyc_d        = '0;
          wr_ptr_d     = '0;
          count_d      = '0;
          timeout_d    = 1'b0;
          trig_cycle_d = '0;
        end else begin
          state_d = ST_FROZEN;
        end
      end

      default: begin
        state_d = ST_ARMED;
      end
    endcase

    done_d = (state_d == ST_FROZEN);

    if (rd_in_range_s) begin
      rd_data_d = mem_q[rd_addr_s];
    end else begin
      rd_data_d = '0;
    end
  end

  // Controller, status and readout registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ARMED;
      cyc_q        <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      post_left_q  <= '0;
      timeout_q    <= 1'b0;
      trig_cycle_q <= '0;
      done_q       <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      post_left_q  <= post_left_d;
      timeout_q    <= timeout_d;
      trig_cycle_q <= trig_cycle_d;
      done_q       <= done_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Trace storage; contents survive rearm and are never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_q[wr_ptr_q] <= wr_data_s;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.count      = count_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.trig_cycle = trig_cycle_q;

endmodule
